// File: rtl/uart_frame_rx.sv
// Frame delineator behind the UART byte receiver: hunts SOF, checks LEN and checksum,
// buffers the payload and replays verified payloads under a downstream ready handshake.
module uart_frame_rx #(
   parameter logic [7:0] SOF_BYTE       = 8'hA5,
   parameter int         MAX_LEN        = 64,
   parameter int         TIMEOUT_CYCLES = 2000,
   parameter int         CNT_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inclk,
   input  logic [7:0]           in,
   input  logic                 downstream_rdy,
   output logic                 outclk,
   output logic [7:0]           out,
   output logic                 out_last,
   output logic                 frame_ok,
   output logic                 frame_err,
   output logic [CNT_WIDTH-1:0] csum_err_cnt,
   output logic [CNT_WIDTH-1:0] len_err_cnt,
   output logic [CNT_WIDTH-1:0] timeout_cnt,
   output logic [CNT_WIDTH-1:0] overrun_cnt
);

   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN     = 3'd1,
      S_PAYLOAD = 3'd2,
      S_CSUM    = 3'd3,
      S_EMIT    = 3'd4
   } state_t;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   state_t               r_state, w_state_nxt;
   logic [LEN_W-1:0]     r_len, w_len_nxt;
   logic [7:0]           r_sum, w_sum_nxt;
   logic [LEN_W-1:0]     r_wr_idx, w_wr_idx_nxt;
   logic [LEN_W-1:0]     r_rd_idx, w_rd_idx_nxt;
   logic [TO_W-1:0]      r_idle_cnt, w_idle_cnt_nxt;
   logic [7:0]           r_out, w_out_nxt;
   logic                 r_outclk, w_outclk_nxt;
   logic                 r_out_last, w_out_last_nxt;
   logic                 r_frame_ok, w_frame_ok_nxt;
   logic                 r_frame_err, w_frame_err_nxt;
   logic [CNT_WIDTH-1:0] r_csum_err_cnt, w_csum_err_cnt_nxt;
   logic [CNT_WIDTH-1:0] r_len_err_cnt, w_len_err_cnt_nxt;
   logic [CNT_WIDTH-1:0] r_timeout_cnt, w_timeout_cnt_nxt;
   logic [CNT_WIDTH-1:0] r_overrun_cnt, w_overrun_cnt_nxt;
   logic [7:0]           r_buf [0:MAX_LEN-1];
   logic                 w_buf_we;
   logic                 w_timeout;
   logic [7:0]           w_sum_in;
   logic [LEN_W-1:0]     w_len_m1;
   logic                 w_len_legal;

   assign w_sum_in    = r_sum + in;
   assign w_len_m1    = r_len - LEN_W'(1);
   assign w_len_legal = (in != 8'h00) && (in <= MAX_LEN_B);

   // Next-state and datapath decode; an arriving byte always takes priority over the timeout.
   always_comb begin
      w_state_nxt        = r_state;
      w_len_nxt          = r_len;
      w_sum_nxt          = r_sum;
      w_wr_idx_nxt       = r_wr_idx;
      w_rd_idx_nxt       = r_rd_idx;
      w_idle_cnt_nxt     = r_idle_cnt;
      w_out_nxt          = r_out;
      w_outclk_nxt       = 1'b0;
      w_out_last_nxt     = 1'b0;
      w_frame_ok_nxt     = 1'b0;
      w_frame_err_nxt    = 1'b0;
      w_csum_err_cnt_nxt = r_csum_err_cnt;
      w_len_err_cnt_nxt  = r_len_err_cnt;
      w_timeout_cnt_nxt  = r_timeout_cnt;
      w_overrun_cnt_nxt  = r_overrun_cnt;
      w_buf_we           = 1'b0;
      w_timeout          = 1'b0;

      if ((r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CSUM)) begin
         if (inclk) begin
            w_idle_cnt_nxt = '0;
         end else if (r_idle_cnt == TO_LAST) begin
            w_idle_cnt_nxt = '0;
            w_timeout      = 1'b1;
         end else begin
            w_idle_cnt_nxt = r_idle_cnt + TO_W'(1);
         end
      end else begin
         w_idle_cnt_nxt = '0;
      end

      case (r_state)
         S_IDLE: begin
            if (inclk && (in == SOF_BYTE)) begin
               w_state_nxt = S_LEN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_LEN: begin
            if (inclk) begin
               w_len_nxt    = in[LEN_W-1:0];
               w_sum_nxt    = in;
               w_wr_idx_nxt = '0;
               if (w_len_legal) begin
                  w_state_nxt = S_PAYLOAD;
               end else begin
                  w_state_nxt       = S_IDLE;
                  w_frame_err_nxt   = 1'b1;
                  w_len_err_cnt_nxt = sat_inc(r_len_err_cnt);
               end
            end else if (w_timeout) begin
               w_state_nxt       = S_IDLE;
               w_frame_err_nxt   = 1'b1;
               w_timeout_cnt_nxt = sat_inc(r_timeout_cnt);
            end else begin
               w_state_nxt = S_LEN;
            end
         end
         S_PAYLOAD: begin
            if (inclk) begin
               w_buf_we  = 1'b1;
               w_sum_nxt = w_sum_in;
               if (r_wr_idx == w_len_m1) begin
                  w_state_nxt  = S_CSUM;
                  w_wr_idx_nxt = '0;
               end else begin
                  w_wr_idx_nxt = r_wr_idx + LEN_W'(1);
               end
            end else if (w_timeout) begin
               w_state_nxt       = S_IDLE;
               w_frame_err_nxt   = 1'b1;
               w_timeout_cnt_nxt = sat_inc(r_timeout_cnt);
            end else begin
               w_state_nxt = S_PAYLOAD;
            end
         end
         S_CSUM: begin
            if (inclk) begin
               w_sum_nxt = w_sum_in;
               if (w_sum_in == 8'h00) begin
                  w_state_nxt    = S_EMIT;
                  w_rd_idx_nxt   = '0;
                  w_frame_ok_nxt = 1'b1;
               end else begin
                  w_state_nxt        = S_IDLE;
                  w_frame_err_nxt    = 1'b1;
                  w_csum_err_cnt_nxt = sat_inc(r_csum_err_cnt);
               end
            end else if (w_timeout) begin
               w_state_nxt       = S_IDLE;
               w_frame_err_nxt   = 1'b1;
               w_timeout_cnt_nxt = sat_inc(r_timeout_cnt);
            end else begin
               w_state_nxt = S_CSUM;
            end
         end
         S_EMIT: begin
            if (inclk) begin
               w_overrun_cnt_nxt = sat_inc(r_overrun_cnt);
            end else begin
               w_overrun_cnt_nxt = r_overrun_cnt;
            end
            if (downstream_rdy) begin
               w_out_nxt    = r_buf[r_rd_idx[IDX_W-1:0]];
               w_outclk_nxt = 1'b1;
               if (r_rd_idx == w_len_m1) begin
                  w_out_last_nxt = 1'b1;
                  w_rd_idx_nxt   = '0;
                  w_state_nxt    = S_IDLE;
               end else begin
                  w_rd_idx_nxt = r_rd_idx + LEN_W'(1);
               end
            end else begin
               w_state_nxt = S_EMIT;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath, strobe and counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_len          <= '0;
         r_sum          <= 8'h00;
         r_wr_idx       <= '0;
         r_rd_idx       <= '0;
         r_idle_cnt     <= '0;
         r_out          <= 8'h00;
         r_outclk       <= 1'b0;
         r_out_last     <= 1'b0;
         r_frame_ok     <= 1'b0;
         r_frame_err    <= 1'b0;
         r_csum_err_cnt <= '0;
         r_len_err_cnt  <= '0;
         r_timeout_cnt  <= '0;
         r_overrun_cnt  <= '0;
      end else begin
         r_len          <= w_len_nxt;
         r_sum          <= w_sum_nxt;
         r_wr_idx       <= w_wr_idx_nxt;
         r_rd_idx       <= w_rd_idx_nxt;
         r_idle_cnt     <= w_idle_cnt_nxt;
         r_out          <= w_out_nxt;
         r_outclk       <= w_outclk_nxt;
         r_out_last     <= w_out_last_nxt;
         r_frame_ok     <= w_frame_ok_nxt;
         r_frame_err    <= w_frame_err_nxt;
         r_csum_err_cnt <= w_csum_err_cnt_nxt;
         r_len_err_cnt  <= w_len_err_cnt_nxt;
         r_timeout_cnt  <= w_timeout_cnt_nxt;
         r_overrun_cnt  <= w_overrun_cnt_nxt;
      end
   end

   // Payload buffer; contents are only meaningful after a verified frame, so no reset.
   always_ff @(posedge clk) begin
      if (w_buf_we) begin
         r_buf[r_wr_idx[IDX_W-1:0]] <= in;
      end
   end

   assign outclk       = r_outclk;
   assign out          = r_out;
   assign out_last     = r_out_last;
   assign frame_ok     = r_frame_ok;
   assign frame_err    = r_frame_err;
   assign csum_err_cnt = r_csum_err_cnt;
   assign len_err_cnt  = r_len_err_cnt;
   assign timeout_cnt  = r_timeout_cnt;
   assign overrun_cnt  = r_overrun_cnt;

endmodule
